// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the loader state encoding and frame layout constants.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Header fields in stream order, SYNC first.
  typedef enum logic [2:0] {
    F_SYNC,
    F_ADDR_LO,
    F_ADDR_HI,
    F_LEN_LO,
    F_LEN_HI
  } field_t;

  localparam logic [7:0] SYNC_DFLT = 8'hA5;
  localparam int         HDR_LEN   = 5;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing 16-bit words into RAM.
// Holds the CPU in reset until a frame loads with a good checksum.
module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 16,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_byte,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_WIDTH-1:0]   dataAddr,
  output logic [2*DATA_WIDTH-1:0] inData,
  output logic                    write_en,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cpu_run
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           cnt;
  logic [7:0]            lowByte;
  logic [7:0]            csum;
  logic [15:0]           lenNext;
  logic                  wrReg;
  logic                  take;

  assign in_ready = !rst && (state != S_DONE);
  assign take     = in_valid && in_ready;
  assign lenNext  = {in_byte, lowByte};

  // A write registered for the reset cycle must not reach RAM.
  assign write_en = wrReg && !rst;
  assign cpu_run  = done;

  // Frame FSM and datapath: header capture, word writes, checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      cnt      <= '0;
      lowByte  <= '0;
      csum     <= '0;
      wrReg    <= 1'b0;
      dataAddr <= '0;
      inData   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wrReg <= 1'b0;
      if (take) begin
        unique case (state)
          S_IDLE: begin
            if (in_byte == SYNC_BYTE) begin
              state <= S_ADDR_LO;
              busy  <= 1'b1;
              csum  <= '0;
            end
          end
          S_ADDR_LO: begin
            lowByte <= in_byte;
            state   <= S_ADDR_HI;
          end
          S_ADDR_HI: begin
            addr  <= ADDR_WIDTH'({in_byte, lowByte & 8'hFE});
            state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            lowByte <= in_byte;
            state   <= S_LEN_HI;
          end
          S_LEN_HI: begin
            cnt   <= lenNext;
            state <= (lenNext == 16'd0) ? S_CSUM : S_DATA_LO;
          end
          S_DATA_LO: begin
            lowByte <= in_byte;
            csum    <= csum ^ in_byte;
            state   <= S_DATA_HI;
          end
          S_DATA_HI: begin
            dataAddr <= addr;
            inData   <= (2*DATA_WIDTH)'({in_byte, lowByte});
            wrReg    <= 1'b1;
            addr     <= addr + ADDR_WIDTH'(2);
            cnt      <= cnt - 16'd1;
            csum     <= csum ^ in_byte;
            state    <= (cnt == 16'd1) ? S_CSUM : S_DATA_LO;
          end
          S_CSUM: begin
            busy <= 1'b0;
            if (in_byte == csum) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              error <= 1'b1;
              state <= S_ERR;
            end
          end
          S_DONE, S_ERR: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader.
// Frames are checked against an arithmetic model of expected writes.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dataAddr;
  logic [15:0] inData;
  logic        write_en;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_run;

  int tests = 0;
  int fails = 0;

  logic [31:0] obsQ[$];
  logic [31:0] expQ[$];
  logic [7:0]  payQ[$];

  prog_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dataAddr (dataAddr),
    .inData   (inData),
    .write_en (write_en),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_run  (cpu_run)
  );

  always #5 clk = ~clk;

  // Record every RAM write seen at mid-cycle.
  always @(negedge clk) begin
    if (write_en === 1'b1) obsQ.push_back({dataAddr, inData});
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int g;
    int n;
    g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    in_valid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    in_byte  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_outs",
        {dataAddr, inData} | 32'({write_en, busy, done, error, cpu_run}),
        32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    obsQ.delete();
  endtask

  task automatic cmpWrites(input string tag);
    int m;
    chk({tag, "_nwr"}, 32'(obsQ.size()), 32'(expQ.size()));
    m = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < m; i++) chk({tag, "_wr"}, obsQ[i], expQ[i]);
  endtask

  // Send one frame built from payQ; csum is corrupted by delta.
  task automatic runFrame(input string tag,
                          input logic [15:0] start,
                          input logic [7:0] delta,
                          input int gapMax);
    int          n;
    logic [7:0]  x;
    logic [15:0] a;
    logic        ok;
    n = payQ.size() / 2;
    x = 8'h00;
    expQ.delete();
    foreach (payQ[i]) x ^= payQ[i];
    for (int k = 0; k < n; k++) begin
      a = (start & 16'hFFFE) + 16'(2 * k);
      expQ.push_back({a, payQ[2*k+1], payQ[2*k]});
    end
    ok = (delta == 8'h00);
    sendByte(8'hA5, gapMax);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    sendByte(start[7:0], gapMax);
    sendByte(start[15:8], gapMax);
    sendByte(8'(n), gapMax);
    sendByte(8'(n >> 8), gapMax);
    foreach (payQ[i]) sendByte(payQ[i], gapMax);
    sendByte(x ^ delta, gapMax);
    chk({tag, "_done"}, 32'(done), 32'(ok));
    chk({tag, "_err"}, 32'(error), 32'(!ok));
    chk({tag, "_run"}, 32'(cpu_run), 32'(ok));
    chk({tag, "_busyoff"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'(!ok));
    if (!ok) begin
      for (int i = 0; i < 3; i++) sendByte(8'($urandom), 0);
      chk({tag, "_errhold"}, 32'(error), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    cmpWrites(tag);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    // Basic load.
    doReset();
    payQ = '{8'h34, 8'h12, 8'h78, 8'h56};
    runFrame("basic", 16'h1000, 8'h00, 0);

    // Bad checksum (09 instead of 08).
    doReset();
    runFrame("badcs", 16'h1000, 8'h01, 0);

    // Zero length.
    doReset();
    payQ.delete();
    runFrame("zero", 16'h2000, 8'h00, 0);

    // Garbage then wrapping frame.
    doReset();
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    chk("garbage_busy", 32'(busy), 32'd0);
    payQ = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    runFrame("wrap", 16'hFFFE, 8'h00, 0);

    // Odd start address is forced even; header byte equal to SYNC.
    doReset();
    payQ = '{8'h01, 8'h02};
    runFrame("odd", 16'hA5A5, 8'h00, 0);

    // Reset in the cycle of the second word's write strobe.
    doReset();
    sendByte(8'hA5, 0);
    sendByte(8'h00, 0);
    sendByte(8'h10, 0);
    sendByte(8'h02, 0);
    sendByte(8'h00, 0);
    sendByte(8'h34, 0);
    sendByte(8'h12, 0);
    sendByte(8'h78, 0);
    sendByte(8'h56, 0);
    chk("mid_wr_pre", 32'(write_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_wr_sup", 32'(write_en), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_outs",
        {dataAddr, inData} | 32'({write_en, busy, done, error, cpu_run}),
        32'd0);
    chk("mid_rdy", 32'(in_ready), 32'd0);
    expQ.delete();
    expQ.push_back({16'h1000, 16'h1234});
    cmpWrites("mid");
    rst = 1'b0;
    #1;
    obsQ.delete();
    payQ = '{8'h34, 8'h12, 8'h78, 8'h56};
    runFrame("after", 16'h1000, 8'h00, 0);

    // Throttled basic frame.
    doReset();
    runFrame("throttle", 16'h1000, 8'h00, 3);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      int          n;
      logic [15:0] st;
      logic [7:0]  d;
      doReset();
      n  = $urandom_range(5, 0);
      st = 16'($urandom);
      d  = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      payQ.delete();
      for (int i = 0; i < 2 * n; i++) payQ.push_back(8'($urandom));
      runFrame("rand", st, d, $urandom_range(2, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that is the write-side initiator for the system's byte-addressed RAM. It accepts a framed byte stream (from a UART receiver or debug link) and writes the payload into RAM as 16-bit little-endian words via the RAM data port (`dataAddr`/`inData`/`write_en`). It holds the CPU in reset until a frame has loaded and its checksum has verified.

## Interface
- `ADDR_WIDTH`, 16: RAM byte-address width.
- `DATA_WIDTH`, 8: RAM byte width; the word written is `2*DATA_WIDTH`.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte. A byte transfers on a cycle where `in_valid && in_ready`.
- `dataAddr`  out  ADDR_WIDTH  RAM write byte address (even by construction).
- `inData`  out  2*DATA_WIDTH  RAM write word, `{hi, lo}`.
- `write_en`  out  1  one-cycle RAM write strobe.
- `busy`  out  1  a frame is in progress (past SYNC, not yet DONE/ERR).
- `done`  out  1  frame loaded and checksum good; sticky.
- `error`  out  1  checksum mismatch; sticky.
- `cpu_run`  out  1  releases CPU reset; equals `done`.

## Operation
- Frame format, byte order on the stream:
  - `SYNC`
  - `ADDR_LO`, `ADDR_HI`: start byte address.
  - `LEN_LO`, `LEN_HI`: word count N, 0..65535.
  - 2N payload bytes, each word sent low byte first.
  - `CSUM`: XOR of all payload bytes; 8'h00 when N = 0.
- States: IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, DONE, ERR.
- IDLE: non-SYNC bytes are accepted and discarded. SYNC goes to ADDR_LO.
- Header states advance one per accepted byte. After LEN_HI:
  - N = 0: go to CSUM.
  - N > 0: go to DATA_LO.
- DATA_LO: latch the low byte, go to DATA_HI.
- DATA_HI: register the word write (see Timing) and decrement the remaining count. Return to DATA_LO if the count is nonzero, else go to CSUM.
- Word address is start + 2*k, computed modulo 2^ADDR_WIDTH, so it wraps past 16'hFFFE to 0. An odd start address is forced even by clearing bit 0.
- The running XOR accumulates every payload byte. A header byte equal to SYNC is treated as data, not a restart.
- CSUM: if the received byte equals the running XOR, go to DONE; otherwise go to ERR.
- DONE: `in_ready` = 0 and the state holds until `rst`.
- ERR: `in_ready` = 1, bytes are drained and discarded, and the state holds until `rst`.

## Timing
- Reset values: `in_ready` 0 while `rst` is high. `dataAddr`, `inData`, `write_en`, `busy`, `done`, `error`, `cpu_run` are all 0. The XOR and counters clear.
- In the first cycle after `rst` deasserts, the state is IDLE and `in_ready` = 1.
- `in_ready` = 1 in every state except DONE; a byte can be accepted every cycle.
- Write latency: `write_en` = 1 exactly in the cycle after the DATA_HI handshake, with `dataAddr` and `inData` valid in that same cycle.
  - `dataAddr` and `inData` hold their values until the next write.
  - Back-to-back words at full rate give `write_en` at most every other cycle. There is no backpressure from RAM.
- `done` or `error` rises in the cycle after the CSUM handshake. `busy` falls in that same cycle.
- `busy` rises in the cycle after the SYNC handshake.
- Reset mid-frame:
  - The frame is aborted and the state returns to IDLE.
  - A write already registered for the reset cycle is suppressed: `write_en` = 0 during `rst`.
  - Words written earlier remain in RAM.
- `in_valid` low in any state causes no state change and no write.

## Structure
- Shared package `loader_pkg`:
  - state enum;
  - `SYNC_BYTE` default;
  - header length constant (5);
  - frame field order.
- Single module, no sub-module. The datapath is:
  - 16-bit address register and incrementer (+2);
  - 16-bit word counter;
  - low-byte latch;
  - 8-bit XOR accumulator.

## Test plan
- Basic load: SYNC, 00 10, 02 00, 34 12, 78 56, CSUM 08 → writes 16'h1234 @ 16'h1000, then 16'h5678 @ 16'h1002. `done` = 1, `cpu_run` = 1, `in_ready` = 0.
- Bad checksum: same frame with CSUM 09 → both writes occur, `error` = 1, `done` = 0, subsequent bytes are accepted and produce no writes.
- Zero length: SYNC, 00 20, 00 00, 00 → no `write_en`, `done` = 1 one cycle after the CSUM handshake.
- Wrap and garbage: bytes 11 22 before SYNC, then FE FF, 02 00, AA BB, CC DD, CSUM 00 → 16'hBBAA @ 16'hFFFE, then 16'hDDCC @ 16'h0000, `done` = 1.
- Reset mid-frame: assert `rst` in the cycle of the second word's `write_en` → that write is suppressed and all outputs go to 0. A fresh full frame afterward loads correctly.
- Throttled input: random `in_valid` gaps on the basic frame → identical writes and result; `write_en` never pulses twice for one word.
